// File: rtl/flags_reg.sv
// flags_reg: registered Z/N/C/V flag unit with sticky
// carry/overflow and a LIFO flag save/restore stack.
module flags_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_we,
  input  logic [4:0]       Opcode,
  input  logic             C_add_sub,
  input  logic [WIDTH-1:0] C_mul,
  input  logic             A_msb,
  input  logic             B_msb,
  input  logic [WIDTH-1:0] R_ula,
  input  logic             push,
  input  logic             pop,
  input  logic             sticky_clr,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             sticky_C,
  output logic             sticky_V,
  output logic [CW-1:0]    stk_count,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          zn, nn, cn, vn;
  logic          is_as, is_mul;
  logic          do_push, do_pop, latch, err_set;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [3:0]    mem [DEPTH];

  always_comb begin
    is_as  = (Opcode[4:1] == 4'b0000);
    is_mul = (Opcode == 5'b00010);
    zn     = ~|R_ula;
    nn     = R_ula[WIDTH-1];
    cn     = 1'b0;
    vn     = 1'b0;
    unique case (1'b1)
      is_as: begin
        cn = C_add_sub;
        // Opcode[0] inverts B for subtraction
        vn = ~(A_msb ^ (B_msb ^ Opcode[0]))
           & (A_msb ^ R_ula[WIDTH-1]);
      end
      is_mul: begin
        cn = |C_mul;
        vn = |C_mul;
      end
      default: ;
    endcase
  end

  assign stk_full  = (stk_count == FULL);
  assign stk_empty = (stk_count == '0);

  assign do_push = push & ~pop & ~stk_full;
  assign do_pop  = pop & ~push & ~stk_empty;
  assign latch   = flag_we & ~pop;
  assign err_set = (push & pop)
                 | (push & ~pop & stk_full)
                 | (pop & ~push & stk_empty);

  assign wr_idx = stk_count[AW-1:0];
  assign rd_idx = AW'(stk_count - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[wr_idx] <= {Z, N, C, V};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {Z, N, C, V} <= 4'b0000;
      sticky_C     <= 1'b0;
      sticky_V     <= 1'b0;
      stk_count    <= '0;
      stk_err      <= 1'b0;
    end else begin
      if (do_pop)
        {Z, N, C, V} <= mem[rd_idx];
      else if (latch)
        {Z, N, C, V} <= {zn, nn, cn, vn};
      sticky_C <= (sticky_C & ~sticky_clr) | (latch & cn);
      sticky_V <= (sticky_V & ~sticky_clr) | (latch & vn);
      if (do_push)
        stk_count <= stk_count + 1'b1;
      else if (do_pop)
        stk_count <= stk_count - 1'b1;
      if (err_set)
        stk_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flags_reg.sv
// tb_flags_reg: directed vectors against a queue-based
// flag/stack model, plus literal spot checks.
module tb_flags_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst, flag_we, C_add_sub, A_msb, B_msb;
  logic             push, pop, sticky_clr;
  logic [4:0]       Opcode;
  logic [WIDTH-1:0] C_mul, R_ula;
  logic             Z, N, C, V, sticky_C, sticky_V;
  logic [CW-1:0]    stk_count;
  logic             stk_full, stk_empty, stk_err;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  logic [3:0] mf;
  logic       msc, msv, merr;
  logic [3:0] stk [$];

  flags_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we),
    .Opcode(Opcode), .C_add_sub(C_add_sub),
    .C_mul(C_mul), .A_msb(A_msb), .B_msb(B_msb),
    .R_ula(R_ula), .push(push), .pop(pop),
    .sticky_clr(sticky_clr),
    .Z(Z), .N(N), .C(C), .V(V),
    .sticky_C(sticky_C), .sticky_V(sticky_V),
    .stk_count(stk_count), .stk_full(stk_full),
    .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Flags from signed-arithmetic meaning, not gate form
  function automatic logic [3:0] nflags();
    logic z, n, c, v, rm;
    rm = R_ula[WIDTH-1];
    z = (R_ula == 0);
    n = rm;
    c = 1'b0;
    v = 1'b0;
    if (Opcode == 5'd0) begin
      c = C_add_sub;
      v = (A_msb == B_msb) && (rm != A_msb);
    end else if (Opcode == 5'd1) begin
      c = C_add_sub;
      v = (A_msb != B_msb) && (rm != A_msb);
    end else if (Opcode == 5'd2) begin
      c = (C_mul != 0);
      v = c;
    end
    return {z, n, c, v};
  endfunction

  always @(posedge clk) begin
    logic [3:0] nf, old;
    nf  = nflags();
    old = mf;
    if (rst) begin
      mf = 4'b0; msc = 1'b0; msv = 1'b0; merr = 1'b0;
      stk.delete();
    end else begin
      if (push && pop) merr = 1'b1;
      else if (pop) begin
        if (stk.size() == 0) merr = 1'b1;
        else mf = stk.pop_back();
      end else begin
        if (push) begin
          if (stk.size() == DEPTH) merr = 1'b1;
          else stk.push_back(old);
        end
        if (flag_we) mf = nf;
      end
      if (sticky_clr) begin msc = 1'b0; msv = 1'b0; end
      if (flag_we && !pop) begin
        msc = msc | nf[1];
        msv = msv | nf[0];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_flags", {4'b0, Z, N, C, V}, {4'b0, mf});
      chk("m_sticky", {6'b0, sticky_C, sticky_V},
          {6'b0, msc, msv});
      chk("m_count", 8'(stk_count), 8'(stk.size()));
      chk("m_full", {7'b0, stk_full},
          {7'b0, stk.size() == DEPTH});
      chk("m_empty", {7'b0, stk_empty},
          {7'b0, stk.size() == 0});
      chk("m_err", {7'b0, stk_err}, {7'b0, merr});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic [4:0] op,
                     input logic [7:0] r,
                     input logic cas,
                     input logic [7:0] cm,
                     input logic a, input logic b,
                     input logic we, input logic ps,
                     input logic pp, input logic sc);
    Opcode = op; R_ula = r; C_add_sub = cas;
    C_mul = cm; A_msb = a; B_msb = b;
    flag_we = we; push = ps; pop = pp; sticky_clr = sc;
    tick();
    flag_we = 0; push = 0; pop = 0; sticky_clr = 0;
  endtask

  task automatic do_rst(input logic ps);
    rst = 1'b1; push = ps;
    tick();
    rst = 1'b0; push = 1'b0;
  endtask

  task automatic lit_f(input string name,
                       input logic [3:0] exp);
    chk(name, {4'b0, Z, N, C, V}, {4'b0, exp});
  endtask

  initial begin
    rst = 0; flag_we = 0; Opcode = 0; C_add_sub = 0;
    C_mul = 0; A_msb = 0; B_msb = 0; R_ula = 0;
    push = 0; pop = 0; sticky_clr = 0;
    @(negedge clk);
    do_rst(1'b0);
    started = 1'b1;
    lit_f("rst_flags", 4'b0000);
    chk("rst_cnt", 8'(stk_count), 8'd0);
    chk("rst_stat", {5'b0, stk_empty, stk_full, stk_err},
        8'b100);

    // ADD overflow
    drv(5'd0, 8'h00, 1, 8'h00, 1, 1, 1, 0, 0, 0);
    lit_f("add_ovf", 4'b1011);
    chk("add_stk", {6'b0, sticky_C, sticky_V}, 8'd3);
    // SUB signed overflow
    drv(5'd1, 8'h80, 0, 8'h00, 0, 1, 1, 0, 0, 0);
    lit_f("sub_ovf", 4'b0101);
    // MUL
    drv(5'd2, 8'h10, 0, 8'h01, 0, 0, 1, 0, 0, 0);
    lit_f("mul_hi", 4'b0011);
    drv(5'd2, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    lit_f("mul_zero", 4'b1000);
    chk("mul_stk", {6'b0, sticky_C, sticky_V}, 8'd3);
    // clear together with a latch of C=1, V=0
    drv(5'd0, 8'h01, 1, 8'h00, 0, 0, 1, 0, 0, 1);
    chk("clr_we", {6'b0, sticky_C, sticky_V}, 8'd2);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    chk("clr_only", {6'b0, sticky_C, sticky_V}, 8'd0);

    // Stack fill with 0001, 0010, 0100, 1000
    do_rst(1'b0);
    drv(5'd0, 8'h01, 0, 8'h00, 1, 1, 1, 0, 0, 0);
    lit_f("f0001", 4'b0001);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    drv(5'd0, 8'h01, 1, 8'h00, 0, 0, 1, 0, 0, 0);
    lit_f("f0010", 4'b0010);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    drv(5'd4, 8'h80, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    lit_f("f0100", 4'b0100);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    lit_f("f1000", 4'b1000);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    chk("fill_cnt", 8'(stk_count), 8'd4);
    chk("fill_err0", {7'b0, stk_err}, 8'd0);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    chk("ovf_cnt", 8'(stk_count), 8'd4);
    chk("ovf_stat", {6'b0, stk_full, stk_err}, 8'd3);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    lit_f("pop1", 4'b1000);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    lit_f("pop2", 4'b0100);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    lit_f("pop3", 4'b0010);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    lit_f("pop4", 4'b0001);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0);
    lit_f("pop_empty", 4'b0001);
    chk("pop_empty_st", {7'b0, stk_empty}, 8'd1);

    // Conflicts
    do_rst(1'b0);
    drv(5'd1, 8'h80, 0, 8'h00, 0, 1, 1, 0, 0, 0);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    drv(5'd0, 8'h01, 1, 8'h00, 0, 0, 1, 0, 0, 0);
    lit_f("cf_pre", 4'b0010);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 0);
    lit_f("pop_we", 4'b0101);
    chk("pop_we_err", {7'b0, stk_err}, 8'd0);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0);
    chk("pp_cnt", 8'(stk_count), 8'd0);
    chk("pp_err", {7'b0, stk_err}, 8'd1);
    lit_f("pp_flags", 4'b0101);
    drv(5'd2, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0);
    lit_f("push_we", 4'b1000);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    lit_f("push_we_old", 4'b0101);

    // Reset mid-operation
    do_rst(1'b0);
    for (int i = 0; i < 3; i++)
      drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 0);
    chk("mid_pre", {4'b0, stk_count, stk_err}, 8'h7);
    do_rst(1'b1);
    lit_f("mid_flags", 4'b0000);
    chk("mid_stat", {4'b0, stk_count, stk_err}, 8'h0);
    chk("mid_empty", {7'b0, stk_empty}, 8'd1);
    drv(5'd4, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    chk("mid_pop_err", {7'b0, stk_err}, 8'd1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/flags_reg.md
Name: flags_reg

Overview:
- Registered, parametrised successor of the combinational ULA flag generator.
- Computes Z/N/C/V from the ULA result and operand MSBs for ADD, SUB and MUL, and latches them on a write strobe.
- Accumulates sticky carry/overflow flags.
- Provides a LIFO flag save/restore stack of configurable depth, for context switches and subroutine calls.
- Sits between the ULA datapath and the control unit; its outputs feed condition evaluation.

Parameters:
- WIDTH, 8: ULA result width; C_mul width (upper WIDTH bits of the product).
- DEPTH, 4: flag stack entries, >=1.
- CW, $clog2(DEPTH+1): width of stk_count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flag_we  input  1  latch newly computed flags this cycle.
- Opcode  input  5  ULA opcode: 00000 ADD, 00001 SUB, 00010 MUL, others logic/move.
- C_add_sub  input  1  carry out of adder/subtractor.
- C_mul  input  WIDTH  upper WIDTH bits of the multiplier product.
- A_msb  input  1  MSB of operand A.
- B_msb  input  1  MSB of operand B.
- R_ula  input  WIDTH  ULA result.
- push  input  1  save current registered {Z,N,C,V} onto the stack.
- pop  input  1  restore {Z,N,C,V} from the stack top.
- sticky_clr  input  1  clear sticky_C and sticky_V.
- Z, N, C, V  output  1 each  registered flags.
- sticky_C  output  1  OR of every C latched since the last clear.
- sticky_V  output  1  OR of every V latched since the last clear.
- stk_count  output  CW  number of valid stack entries.
- stk_full  output  1  stk_count == DEPTH.
- stk_empty  output  1  stk_count == 0.
- stk_err  output  1  sticky error for stack overflow, underflow or conflict; cleared only by rst.

Behaviour:
- Reset: one cycle of rst drives Z, N, C, V, sticky_C, sticky_V, stk_err and stk_count to 0, so stk_empty=1 and stk_full=0.
  - Stack contents are don't-care after reset.
  - rst overrides every other input in the same cycle, including mid-sequence push/pop.
- Next-flag computation (combinational, internal):
  - Zn = ~|R_ula; Nn = R_ula[WIDTH-1].
  - ADD/SUB (Opcode[4:1]==0): Cn = C_add_sub; Vn = ~(A_msb ^ (B_msb ^ Opcode[0])) & (A_msb ^ R_ula[WIDTH-1]).
  - MUL (Opcode==00010): Cn = Vn = |C_mul.
  - All other opcodes: Cn = Vn = 0.
- Latency: flags are visible one cycle after flag_we. Outputs never change combinationally from inputs.
- Priority per cycle: rst > pop > flag_we. push is evaluated against the pre-edge flag values.
- push alone, not full:
  - mem[stk_count] <= {Z,N,C,V} (current registered values); stk_count++.
  - If flag_we is also set, flags update to the new values while the old values are saved.
- push when full: ignored; stk_count unchanged; stk_err <= 1.
- pop alone, not empty: {Z,N,C,V} <= mem[stk_count-1]; stk_count--. Any flag_we in the same cycle is discarded.
- pop when empty: flags unchanged; flag_we in the same cycle is still discarded; stk_err <= 1.
- push and pop in the same cycle: no stack operation, flags unchanged, stk_err <= 1.
- Sticky flags:
  - Update only when flag_we latches (not on pop): sticky_X <= sticky_X | Xn.
  - If sticky_clr is set in the same cycle, sticky_X <= Xn (the clear applies first, then the new value is ORed in).
- stk_count never wraps. It saturates at 0 and DEPTH by the ignore rules above.

Test Plan:
- ADD overflow: Opcode=00000, R_ula=0x00, C_add_sub=1, A_msb=1, B_msb=1, flag_we=1 -> next cycle Z=1, N=0, C=1, V=1, sticky_C=sticky_V=1.
- SUB signed overflow: Opcode=00001, A_msb=0, B_msb=1, R_ula=0x80, C_add_sub=0, flag_we=1 -> Z=0, N=1, C=0, V=1.
- MUL: C_mul=0x01, R_ula=0x10 -> C=V=1, Z=0, N=0. Then C_mul=0x00, R_ula=0x00 -> C=V=0, Z=1, sticky_C/V stay 1 until sticky_clr.
- Stack fill/drain (DEPTH=4):
  - Latch flags 0001, 0010, 0100, 1000 (ZNCV order), pushing each.
  - 5th push -> stk_full=1, stk_err=1, stk_count stays 4.
  - Four pops restore 1000, 0100, 0010, 0001 in turn.
  - 5th pop -> flags unchanged, stk_empty=1.
- Conflicts:
  - pop with flag_we (R_ula=0x00) -> restored value wins and Z is not forced to 1.
  - push+pop together -> stk_count unchanged, stk_err=1.
  - push with flag_we -> stack holds the old flags, outputs show the new flags.
- Reset mid-operation: after 3 pushes and stk_err=1, assert rst one cycle together with push=1 -> all outputs 0, stk_empty=1; next pop sets stk_err=1 again.
